// File: rtl/huffman_block_sequencer.sv
// huffman_block_sequencer: drives Huffman_Decoder through one 8x8 block and emits nonzero coefficients with zig-zag index
// Ports: clk/rst (async active-high); start/dc_pred_clear control; bit_in/bit_valid/bit_ready serial stream;
// hd_* decoder handshake; coef_value/coef_index/coef_valid coefficient stream; block_done/busy/error status.
module huffman_block_sequencer #(
  parameter int COEF_W    = 12,
  parameter int BLOCK_LEN = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              dc_pred_clear,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic              bit_ready,
  output logic              hd_ac_dc_flag,
  output logic              hd_next_bit,
  output logic              hd_is_new,
  input  logic [3:0]        hd_s_value,
  input  logic [3:0]        hd_r_value,
  input  logic              hd_done,
  output logic [COEF_W-1:0] coef_value,
  output logic [5:0]        coef_index,
  output logic              coef_valid,
  output logic              block_done,
  output logic              busy,
  output logic              error
);
  typedef enum logic [2:0] {IDLE, SYM, MAG, EMIT, DONE, ERR} state_t;
  localparam logic [6:0] K_END  = 7'(BLOCK_LEN);
  localparam logic [6:0] K_LAST = 7'(BLOCK_LEN - 1);
  state_t            state_q, state_d;
  logic [6:0]        k_q, k_d, k_s, k_z;
  logic [COEF_W-1:0] dc_pred_q, dc_pred_d, coef_value_q, coef_value_d;
  logic [3:0]        mag_cnt_q, mag_cnt_d, r_q, r_d;
  logic [10:0]       mag_shift_q, mag_shift_d;
  logic [5:0]        coef_index_q, coef_index_d;
  logic              hd_ac_dc_flag_q, hd_ac_dc_flag_d, coef_valid_q, coef_valid_d;
  logic              block_done_q, block_done_d, busy_q, busy_d, error_q, error_d;
  logic [COEF_W-1:0] lim, mag_ext, val;
  // The decoder only sees bits while a symbol is in flight; the hd_done cycle consumes nothing.
  assign bit_ready     = (state_q == SYM && !hd_done) || state_q == MAG;
  assign hd_is_new     = state_q == SYM && !hd_done && bit_valid;
  assign hd_next_bit   = state_q == SYM && bit_in;
  assign hd_ac_dc_flag = hd_ac_dc_flag_q;
  assign coef_value    = coef_value_q;
  assign coef_index    = coef_index_q;
  assign coef_valid    = coef_valid_q;
  assign block_done    = block_done_q;
  assign busy          = busy_q;
  assign error         = error_q;
  always_comb begin
    state_d = state_q;
    k_d = k_q;
    dc_pred_d = dc_pred_q;
    mag_cnt_d = mag_cnt_q;
    mag_shift_d = mag_shift_q;
    r_d = r_q;
    hd_ac_dc_flag_d = hd_ac_dc_flag_q;
    coef_value_d = coef_value_q;
    coef_index_d = coef_index_q;
    coef_valid_d = 1'b0;
    block_done_d = 1'b0;
    busy_d = busy_q;
    error_d = error_q;
    k_s = k_q + 7'(hd_s_value);
    k_z = k_q + 7'd16;
    case (state_q)
      IDLE: begin
        if (dc_pred_clear) dc_pred_d = '0;
        if (start) begin
          error_d = 1'b0;
          k_d = '0;
          hd_ac_dc_flag_d = 1'b1;
          busy_d = 1'b1;
          state_d = SYM;
        end
      end
      SYM: if (hd_done) begin
        r_d = hd_r_value;
        mag_cnt_d = hd_r_value;
        mag_shift_d = '0;
        if (hd_ac_dc_flag_q) state_d = hd_r_value > 4'd11 ? ERR : (hd_r_value == 4'd0 ? EMIT : MAG);
        else if (hd_r_value != 4'd0) begin
          k_d = k_s;
          state_d = k_s > K_LAST ? ERR : MAG;
        end else if (hd_s_value == 4'd0) state_d = DONE;
        else if (hd_s_value == 4'hf) begin
          k_d = k_z;
          state_d = k_z > K_LAST ? ERR : SYM;
        end else state_d = ERR;
      end
      MAG: if (bit_valid) begin
        mag_shift_d = {mag_shift_q[9:0], bit_in};
        mag_cnt_d = mag_cnt_q - 4'd1;
        if (mag_cnt_q == 4'd1) state_d = EMIT;
      end
      EMIT: state_d = k_q == K_END ? DONE : SYM;
      default: state_d = IDLE;
    endcase
    // lim = 2^r - 1; a clear top magnitude bit marks a negative value.
    lim = (COEF_W'(1) << r_d) - COEF_W'(1);
    mag_ext = COEF_W'(mag_shift_d);
    val = |(mag_ext & lim & ~(lim >> 1)) ? mag_ext : mag_ext - lim;
    // Coefficient registers load on entry so coef_valid is high during the EMIT cycle.
    if (state_d == EMIT) begin
      coef_valid_d = 1'b1;
      hd_ac_dc_flag_d = 1'b0;
      coef_value_d = hd_ac_dc_flag_q ? dc_pred_q + val : val;
      coef_index_d = hd_ac_dc_flag_q ? 6'd0 : k_q[5:0];
      k_d = hd_ac_dc_flag_q ? 7'd1 : k_q + 7'd1;
      dc_pred_d = hd_ac_dc_flag_q ? dc_pred_q + val : dc_pred_q;
    end
    if (state_d == DONE) begin
      block_done_d = 1'b1;
      busy_d = 1'b0;
      hd_ac_dc_flag_d = 1'b0;
    end
    if (state_d == ERR) begin
      error_d = 1'b1;
      busy_d = 1'b0;
      hd_ac_dc_flag_d = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q <= '0;
      dc_pred_q <= '0;
      mag_cnt_q <= '0;
      mag_shift_q <= '0;
      r_q <= '0;
      hd_ac_dc_flag_q <= 1'b0;
      coef_value_q <= '0;
      coef_index_q <= '0;
      coef_valid_q <= 1'b0;
      block_done_q <= 1'b0;
      busy_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      dc_pred_q <= dc_pred_d;
      mag_cnt_q <= mag_cnt_d;
      mag_shift_q <= mag_shift_d;
      r_q <= r_d;
      hd_ac_dc_flag_q <= hd_ac_dc_flag_d;
      coef_value_q <= coef_value_d;
      coef_index_q <= coef_index_d;
      coef_valid_q <= coef_valid_d;
      block_done_q <= block_done_d;
      busy_q <= busy_d;
      error_q <= error_d;
    end
  end
endmodule
